stream_frame_chk: RTL and testbench
===================================

Name: stream_frame_chk

Overview:
Downstream consumer of the rotating register-file reader. It takes the 32-bit word stream, locks onto the repeating frame 1,2,...,ADDR_COUNT, and checks every word against the expected value. For each complete frame it reports the frame sum, and it counts sequence errors. Used as the self-check and monitor stage behind the register-file read loop.

Parameters:
ADDR_WIDTH, 2, log2 of frame length; must match the upstream reader.
ADDR_COUNT, 1 << ADDR_WIDTH, words per frame.
DATA_WIDTH, 32, stream word width.
SUM_WIDTH, DATA_WIDTH + ADDR_WIDTH, frame-sum width; no overflow possible.
ERR_WIDTH, 8, error-counter width.

Ports:
i_clk  input  1  clock, rising edge.
i_rst_n  input  1  reset, asynchronous, active-low.
i_en  input  1  word-valid qualifier; i_data is consumed only on cycles where i_en=1.
i_data  input  DATA_WIDTH  stream word from the upstream reader.
i_clr  input  1  synchronous clear of the error count; also forces HUNT.
o_locked  output  1  high while in CHECK after at least one full good frame.
o_sum  output  SUM_WIDTH  sum of the last completed frame.
o_sum_vld  output  1  one-cycle pulse; o_sum is new on that cycle.
o_err  output  1  one-cycle pulse per mismatched word.
o_err_cnt  output  ERR_WIDTH  saturating mismatch count.

Behaviour:
- Reset (async assert on i_rst_n low):
  - state=HUNT; idx=0; expected=1; acc=0.
  - o_locked=0, o_sum=0, o_sum_vld=0, o_err=0, o_err_cnt=0.
- All outputs are registered. Response latency is 1 cycle after the consuming edge.
- Cycles with i_en=0 change nothing except clearing the o_sum_vld/o_err pulses.
- FSM HUNT (on i_en=1):
  - i_data==1 -> go to CHECK; acc=1; idx=1; expected=2.
  - Any other value is discarded silently: no error, no count.
- FSM CHECK (on i_en=1):
  - Match (i_data==expected):
    - acc+=i_data; idx++; expected++.
    - If idx==ADDR_COUNT-1 (last word of the frame): o_sum<=acc+i_data; o_sum_vld pulses; o_locked<=1; acc=0; idx=0; expected=1 (wrap).
  - Mismatch:
    - o_err pulses; o_err_cnt++ (saturates at 2^ERR_WIDTH-1, holds); o_locked<=0; acc discarded.
    - The mismatched word is re-evaluated as in HUNT in the same cycle: if it equals 1, the FSM enters CHECK with acc=1, idx=1, expected=2; otherwise it goes to HUNT.
- Compare width: i_data is compared on the full DATA_WIDTH against expected, zero-extended.
- Frame sum: the exact value is ADDR_COUNT*(ADDR_COUNT+1)/2, i.e. 10 at defaults. The block reports o_sum and does not compare it to this value.
- i_clr=1:
  - o_err_cnt=0; state=HUNT; o_locked=0; acc/idx cleared; the word on that cycle is ignored.
  - i_clr wins over a simultaneous mismatch: count is 0 and no o_err pulse.
- o_sum holds its last value until the next frame completes; it is not cleared by a mismatch.
- Reset mid-frame: everything returns to reset values immediately; the partial frame is lost.

Test Plan:
1. Release reset, i_en=1, stream 1,2,3,4,1,2,3,4 -> o_sum_vld pulses the cycle after each 4; o_sum=10 both times; o_locked=1 after the first frame; o_err_cnt=0.
2. Stream 7,9,1,2,3,4 -> no o_err during 7 and 9; one o_sum_vld with o_sum=10; o_locked rises after the 4.
3. Locked, then stream 1,2,5,4,1,2,3,4 -> o_err pulse on 5 and o_err_cnt=1; o_locked drops; 4 is discarded in HUNT; next frame gives o_sum=10 and relocks. Variant 1,2,1,2,3,4 -> one error, and the second 1 starts the frame, giving o_sum=10.
4. Toggle i_en (1,gap,2,gap,gap,3,4) -> gaps ignored; o_sum=10; no errors.
5. ERR_WIDTH=2, force 5 mismatches -> o_err_cnt sticks at 3. Then i_clr together with a mismatch -> o_err_cnt=0, no o_err pulse, state HUNT.
6. Assert i_rst_n low after the stream 1,2 -> all outputs 0 asynchronously. After release, 3,4,1,2,3,4 -> only one frame reported (o_sum=10).

Source files
------------

// File: rtl/stream_frame_chk.sv
// Frame checker for the rotating register-file read stream: locks onto the
// repeating 1..ADDR_COUNT sequence, reports per-frame sums and counts mismatches.
module stream_frame_chk #(
  parameter int ADDR_WIDTH = 2,
  parameter int ADDR_COUNT = 1 << ADDR_WIDTH,
  parameter int DATA_WIDTH = 32,
  parameter int SUM_WIDTH  = DATA_WIDTH + ADDR_WIDTH,
  parameter int ERR_WIDTH  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_clr,
  output logic                  o_locked,
  output logic [SUM_WIDTH-1:0]  o_sum,
  output logic                  o_sum_vld,
  output logic                  o_err,
  output logic [ERR_WIDTH-1:0]  o_err_cnt
);

  typedef enum logic {
    HUNT  = 1'b0,
    CHECK = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(ADDR_COUNT - 1);
  localparam logic [DATA_WIDTH-1:0] ONE      = DATA_WIDTH'(1);
  localparam logic [ERR_WIDTH-1:0]  ERR_MAX  = '1;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0] exp_q, exp_d;
  logic [SUM_WIDTH-1:0]  acc_q, acc_d;
  logic                  locked_q, locked_d;
  logic [SUM_WIDTH-1:0]  sum_q, sum_d;
  logic                  sum_vld_q, sum_vld_d;
  logic                  err_q, err_d;
  logic [ERR_WIDTH-1:0]  err_cnt_q, err_cnt_d;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    exp_d     = exp_q;
    acc_d     = acc_q;
    locked_d  = locked_q;
    sum_d     = sum_q;
    sum_vld_d = 1'b0;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;

    if (i_clr) begin
      state_d   = HUNT;
      idx_d     = '0;
      exp_d     = ONE;
      acc_d     = '0;
      locked_d  = 1'b0;
      err_cnt_d = '0;
    end else if (i_en) begin
      if (state_q == CHECK && i_data == exp_q) begin
        if (idx_q == LAST_IDX) begin
          sum_d     = acc_q + SUM_WIDTH'(i_data);
          sum_vld_d = 1'b1;
          locked_d  = 1'b1;
          acc_d     = '0;
          idx_d     = '0;
          exp_d     = ONE;
        end else begin
          acc_d = acc_q + SUM_WIDTH'(i_data);
          idx_d = idx_q + ADDR_WIDTH'(1);
          exp_d = exp_q + ONE;
        end
      end else begin
        if (state_q == CHECK) begin
          err_d     = 1'b1;
          locked_d  = 1'b0;
          err_cnt_d = (err_cnt_q == ERR_MAX) ? err_cnt_q : err_cnt_q + ERR_WIDTH'(1);
        end
        // A rejected word is treated exactly as HUNT would: a 1 restarts the frame.
        if (i_data == ONE) begin
          state_d = CHECK;
          acc_d   = SUM_WIDTH'(1);
          idx_d   = ADDR_WIDTH'(1);
          exp_d   = DATA_WIDTH'(2);
        end else begin
          state_d = HUNT;
          acc_d   = '0;
          idx_d   = '0;
          exp_d   = ONE;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= HUNT;
      idx_q     <= '0;
      exp_q     <= ONE;
      acc_q     <= '0;
      locked_q  <= 1'b0;
      sum_q     <= '0;
      sum_vld_q <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      exp_q     <= exp_d;
      acc_q     <= acc_d;
      locked_q  <= locked_d;
      sum_q     <= sum_d;
      sum_vld_q <= sum_vld_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign o_locked  = locked_q;
  assign o_sum     = sum_q;
  assign o_sum_vld = sum_vld_q;
  assign o_err     = err_q;
  assign o_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_stream_frame_chk.sv
// Bench for stream_frame_chk: a directed vector table, hand-written corner sequences,
// then random traffic scored against a frame-position reference model.
module tb_stream_frame_chk;

  localparam int N = 4;
  localparam logic [33:0] FRAME_SUM = 34'(N * (N + 1) / 2);

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        clr;
  logic [31:0] data;

  logic        lk, vld, err;
  logic [33:0] sum;
  logic [7:0]  cnt;
  logic        lk2, vld2, err2;
  logic [33:0] sum2;
  logic [1:0]  cnt2;

  int total;
  int bad;

  // Reference model: position inside the current frame plus the observable outputs.
  bit          mInCheck;
  int          mPos;
  bit          mLocked;
  logic [33:0] mSum;
  bit          mVld;
  bit          mErr;
  int          mCnt;
  int          mCnt2;

  typedef struct {
    logic        en;
    logic        clr;
    logic [31:0] data;
    logic        vld;
    logic [33:0] sum;
    logic        err;
    logic [7:0]  cnt;
    logic        lk;
  } vec_t;

  vec_t tbl[$];

  stream_frame_chk dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_data(data), .i_clr(clr),
    .o_locked(lk), .o_sum(sum), .o_sum_vld(vld), .o_err(err), .o_err_cnt(cnt)
  );

  stream_frame_chk #(.ERR_WIDTH(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_data(data), .i_clr(clr),
    .o_locked(lk2), .o_sum(sum2), .o_sum_vld(vld2), .o_err(err2), .o_err_cnt(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic resetModel();
    mInCheck = 0; mPos = 0; mLocked = 0; mSum = '0;
    mVld = 0; mErr = 0; mCnt = 0; mCnt2 = 0;
  endtask

  task automatic stepModel(input logic e, input logic c, input logic [31:0] d);
    mVld = 0;
    mErr = 0;
    if (c) begin
      mInCheck = 0; mPos = 0; mLocked = 0; mCnt = 0; mCnt2 = 0;
    end else if (e) begin
      if (mInCheck && d == 32'(mPos + 1)) begin
        mPos++;
        if (mPos == N) begin
          mSum = FRAME_SUM; mVld = 1; mLocked = 1; mPos = 0;
        end
      end else begin
        if (mInCheck) begin
          mErr = 1; mLocked = 0;
          if (mCnt < 255) mCnt++;
          if (mCnt2 < 3) mCnt2++;
        end
        mInCheck = (d == 32'd1);
        mPos = mInCheck ? 1 : 0;
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  // Drive on the falling edge, consume on the rising edge, sample 1 time unit later.
  task automatic applyStimulus(input logic e, input logic c, input logic [31:0] d);
    @(negedge clk);
    en = e; clr = c; data = d;
    @(posedge clk);
    stepModel(e, c, d);
    #1;
  endtask

  task automatic addRow(input logic e, input logic c, input logic [31:0] d, input logic v,
                        input logic [33:0] s, input logic er, input logic [7:0] cn, input logic l);
    vec_t r;
    r.en = e; r.clr = c; r.data = d; r.vld = v; r.sum = s; r.err = er; r.cnt = cn; r.lk = l;
    tbl.push_back(r);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; data = '0;
    resetModel();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, ".vld"}, 64'(vld), 64'(mVld));
    checkOutput({tag, ".sum"}, 64'(sum), 64'(mSum));
    checkOutput({tag, ".err"}, 64'(err), 64'(mErr));
    checkOutput({tag, ".cnt"}, 64'(cnt), 64'(mCnt));
    checkOutput({tag, ".lk"}, 64'(lk), 64'(mLocked));
    checkOutput({tag, ".cnt2"}, 64'(cnt2), 64'(mCnt2));
    checkOutput({tag, ".lk2"}, 64'(lk2), 64'(mLocked));
    checkOutput({tag, ".err2"}, 64'(err2), 64'(mErr));
  endtask

  initial begin
    logic [31:0] d;
    int r;
    total = 0;
    bad = 0;
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; data = '0;
    resetModel();

    // Two clean frames from reset.
    addRow(1,0,1, 0,0,0,0,0);  addRow(1,0,2, 0,0,0,0,0);
    addRow(1,0,3, 0,0,0,0,0);  addRow(1,0,4, 1,10,0,0,1);
    addRow(1,0,1, 0,10,0,0,1); addRow(1,0,2, 0,10,0,0,1);
    addRow(1,0,3, 0,10,0,0,1); addRow(1,0,4, 1,10,0,0,1);
    // Clear back to HUNT, then junk words are dropped silently before a frame.
    addRow(1,1,5, 0,10,0,0,0);
    addRow(1,0,7, 0,10,0,0,0); addRow(1,0,9, 0,10,0,0,0);
    addRow(1,0,1, 0,10,0,0,0); addRow(1,0,2, 0,10,0,0,0);
    addRow(1,0,3, 0,10,0,0,0); addRow(1,0,4, 1,10,0,0,1);
    // Mismatch on 5, trailing 4 discarded in HUNT, relock.
    addRow(1,0,1, 0,10,0,0,1); addRow(1,0,2, 0,10,0,0,1);
    addRow(1,0,5, 0,10,1,1,0); addRow(1,0,4, 0,10,0,1,0);
    addRow(1,0,1, 0,10,0,1,0); addRow(1,0,2, 0,10,0,1,0);
    addRow(1,0,3, 0,10,0,1,0); addRow(1,0,4, 1,10,0,1,1);
    // Mismatching 1 restarts the frame immediately.
    addRow(1,0,1, 0,10,0,1,1); addRow(1,0,2, 0,10,0,1,1);
    addRow(1,0,1, 0,10,1,2,0); addRow(1,0,2, 0,10,0,2,0);
    addRow(1,0,3, 0,10,0,2,0); addRow(1,0,4, 1,10,0,2,1);
    // Gaps with i_en low are ignored even when the data would mismatch.
    addRow(1,0,1, 0,10,0,2,1); addRow(0,0,1, 0,10,0,2,1);
    addRow(1,0,2, 0,10,0,2,1); addRow(0,0,1, 0,10,0,2,1);
    addRow(0,0,7, 0,10,0,2,1); addRow(1,0,3, 0,10,0,2,1);
    addRow(1,0,4, 1,10,0,2,1); addRow(0,0,4, 0,10,0,2,1);

    #12;
    checkOutput("rst.lk",  64'(lk),  64'd0);
    checkOutput("rst.sum", 64'(sum), 64'd0);
    checkOutput("rst.vld", 64'(vld), 64'd0);
    checkOutput("rst.err", 64'(err), 64'd0);
    checkOutput("rst.cnt", 64'(cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].en, tbl[i].clr, tbl[i].data);
      checkOutput($sformatf("tbl%0d.vld", i), 64'(vld), 64'(tbl[i].vld));
      checkOutput($sformatf("tbl%0d.sum", i), 64'(sum), 64'(tbl[i].sum));
      checkOutput($sformatf("tbl%0d.err", i), 64'(err), 64'(tbl[i].err));
      checkOutput($sformatf("tbl%0d.cnt", i), 64'(cnt), 64'(tbl[i].cnt));
      checkOutput($sformatf("tbl%0d.lk", i),  64'(lk),  64'(tbl[i].lk));
      checkOutput($sformatf("tbl%0d.cnt2", i), 64'(cnt2), 64'(tbl[i].cnt));
    end

    // Saturation: five mismatches; the 2-bit counter sticks at 3.
    applyStimulus(1, 1, 0);
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1, 0, 1);
      applyStimulus(1, 0, 5);
      checkOutput($sformatf("sat%0d.err", k), 64'(err), 64'd1);
      checkOutput($sformatf("sat%0d.cnt", k), 64'(cnt), 64'(k));
      checkOutput($sformatf("sat%0d.cnt2", k), 64'(cnt2), 64'(k > 3 ? 3 : k));
    end

    // Asynchronous reset mid-frame, away from any clock edge.
    applyStimulus(1, 0, 1); applyStimulus(1, 0, 2); applyStimulus(1, 0, 3);
    applyStimulus(1, 0, 4); applyStimulus(1, 0, 1); applyStimulus(1, 0, 2);
    checkOutput("pre.lk", 64'(lk), 64'd1);
    #2;
    rst_n = 1'b0;
    resetModel();
    #1;
    checkOutput("arst.lk",   64'(lk),   64'd0);
    checkOutput("arst.sum",  64'(sum),  64'd0);
    checkOutput("arst.cnt",  64'(cnt),  64'd0);
    checkOutput("arst.cnt2", 64'(cnt2), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, 0, 3);
    checkOutput("post3.err", 64'(err), 64'd0);
    applyStimulus(1, 0, 4);
    checkOutput("post4.vld", 64'(vld), 64'd0);
    applyStimulus(1, 0, 1); applyStimulus(1, 0, 2); applyStimulus(1, 0, 3);
    applyStimulus(1, 0, 4);
    checkOutput("postF.vld", 64'(vld), 64'd1);
    checkOutput("postF.sum", 64'(sum), 64'(FRAME_SUM));
    checkOutput("postF.lk",  64'(lk),  64'd1);

    // Clear wins over a simultaneous mismatch, and leaves the FSM in HUNT.
    applyStimulus(1, 0, 1); applyStimulus(1, 0, 7);
    checkOutput("pre.cnt", 64'(cnt), 64'd1);
    applyStimulus(1, 0, 1);
    applyStimulus(1, 1, 5);
    checkOutput("clr.err",  64'(err),  64'd0);
    checkOutput("clr.cnt",  64'(cnt),  64'd0);
    checkOutput("clr.cnt2", 64'(cnt2), 64'd0);
    checkOutput("clr.lk",   64'(lk),   64'd0);
    applyStimulus(1, 0, 3);
    checkOutput("hunt.err", 64'(err), 64'd0);
    checkOutput("hunt.cnt", 64'(cnt), 64'd0);

    // Random traffic, mostly well-formed with injected faults, gaps and clears.
    doReset();
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 65)      d = mInCheck ? 32'(mPos + 1) : 32'd1;
      else if (r < 92) d = 32'($urandom_range(0, 6));
      else             d = $urandom;
      applyStimulus($urandom_range(0, 9) < 8, $urandom_range(0, 99) < 3, d);
      checkModel($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
